// File: rtl/mem_requester_pkg.sv
// mem_requester_pkg: shared widths, read latency and FSM encoding for mem_requester.
package mem_requester_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int RD_LAT_DEF = 2;
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/mem_requester_if.sv
// mem_requester_if: command, write-data, read-response and memory-port signals of mem_requester.
interface mem_requester_if
    import mem_requester_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              wr_done;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, mem_rdata,
        output req_ready, wd_ready, wr_done, rsp_valid, rsp_data, rsp_last,
               mem_write, mem_read, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, mem_rdata,
        input  req_ready, wd_ready, wr_done, rsp_valid, rsp_data, rsp_last,
               mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_requester_rd_track.sv
// mem_requester_rd_track: RD_LAT-deep {valid,last} delay line that lines read responses up with mem_rdata.
module mem_requester_rd_track
    import mem_requester_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);
    logic [RD_LAT-1:0] vld_q, vld_d, lst_q, lst_d;

    always_comb begin
        vld_d = (vld_q << 1) | RD_LAT'(in_valid);
        lst_d = (lst_q << 1) | RD_LAT'(in_valid & in_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_last  = lst_q[RD_LAT-1];
endmodule

// File: rtl/mem_requester.sv
// mem_requester: turns 1..4-beat read/write burst commands into cycles on a memory
// with RD_LAT-cycle registered reads.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input logic clk,
    input logic rst,
    mem_requester_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_beat, wr, issue, beat, trk_valid, trk_last;

    assign last_beat = cnt_q == 2'd0;
    assign wr        = state_q == WRITE && bus.wd_valid;
    assign issue     = state_q == READ;
    assign beat      = wr || issue;

    always_comb begin
        state_d = state_q;
        addr_d  = beat ? addr_q + ADDR_W'(1) : addr_q;
        cnt_d   = beat ? cnt_q - 2'd1 : cnt_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr;
                cnt_d   = bus.req_len;
                state_d = bus.req_write ? WRITE : READ;
            end
            WRITE:   if (wr && last_beat) state_d = DONE;
            READ:    if (last_beat) state_d = DRAIN;
            // the memory output register must keep advancing until the last beat leaves it
            DRAIN:   if (trk_last) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_requester_rd_track #(.RD_LAT(RD_LAT)) u_rd_track (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_last   (last_beat),
        .out_valid (trk_valid),
        .out_last  (trk_last)
    );

    assign bus.req_ready = state_q == IDLE;
    assign bus.wd_ready  = state_q == WRITE;
    assign bus.wr_done   = state_q == DONE;
    assign bus.mem_write = wr;
    assign bus.mem_read  = issue || state_q == DRAIN;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wr ? bus.wd_data : DATA_W'(0);
    assign bus.rsp_valid = trk_valid;
    assign bus.rsp_last  = trk_last;
    assign bus.rsp_data  = bus.mem_rdata;
endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter DATA_W, 8, memory word width.
REQ-002 Parameter ADDR_W, 4, memory address width (16 words).
REQ-003 Parameter RD_LAT, 2, cycles from a read-issue edge to valid mem_rdata.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  1  command present.
REQ-007 req_ready  out  1  command accepted when high with req_valid.
REQ-008 req_write  in  1  1 = write burst, 0 = read burst.
REQ-009 req_addr  in  ADDR_W  burst start address.
REQ-010 req_len  in  2  beats minus one (1..4 beats).
REQ-011 wd_valid  in  1  write data beat present.
REQ-012 wd_ready  out  1  write beat consumed when high with wd_valid.
REQ-013 wd_data  in  DATA_W  write beat data.
REQ-014 wr_done  out  1  one-cycle pulse, write burst complete.
REQ-015 rsp_valid  out  1  read beat valid; no backpressure.
REQ-016 rsp_data  out  DATA_W  read beat data.
REQ-017 rsp_last  out  1  final read beat of burst.
REQ-018 mem_write  out  1  memory write enable (wre).
REQ-019 mem_read  out  1  memory output-register enable (oce).
REQ-020 mem_addr  out  ADDR_W  memory address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data.

Function
REQ-023 FSM states SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-024 IDLE: req_ready=1; on req_valid capture write/addr/len into registers, beat counter=len, go WRITE or READ.
REQ-025 req_ready SHALL be 0 in every state other than IDLE.
REQ-026 WRITE: wd_ready=1; each cycle with wd_valid drives mem_write=1, mem_addr=current addr, mem_wdata=wd_data combinationally, then increments addr and decrements counter.
REQ-027 WRITE with wd_valid=0: mem_write=0, no state change (stall any length).
REQ-028 After last write beat -> DONE; DONE asserts wr_done=1 for exactly one cycle, then IDLE.
REQ-029 READ: mem_read=1, one address issued per cycle, no gaps; after last issue -> DRAIN.
REQ-030 DRAIN: mem_read=1 held until the final response is delivered, then IDLE (no DONE visit, wr_done=0).
REQ-031 Response tracking: RD_LAT-deep shift register of {valid,last} flags; rsp_valid/rsp_last emitted exactly RD_LAT cycles after corresponding issue edge; rsp_data=mem_rdata.
REQ-032 Address arithmetic modulo 2^ADDR_W: 4'hF + 1 wraps to 4'h0 within a burst.
REQ-033 Read burst of N beats SHALL produce exactly N rsp_valid cycles, consecutive, rsp_last only on the Nth.
REQ-034 mem_write and mem_read SHALL never be high in the same cycle; mem_write=0 outside WRITE.
REQ-035 Next command accepted no earlier than the cycle after returning to IDLE.

Reset
REQ-036 rst high at any edge, including mid-burst: state=IDLE, counter/addr=0, flag pipeline cleared.
REQ-037 Outputs during and after reset: req_ready=1 (IDLE), wd_ready=0, wr_done=0, rsp_valid=0, rsp_last=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
REQ-038 Responses in flight at reset SHALL be discarded; no rsp_valid after rst deasserts until a new read is issued.

Structure
REQ-039 Shared package holds DATA_W/ADDR_W defaults, RD_LAT, and the FSM state encoding.
REQ-040 One sub-module, rd_track (valid/last delay line, depth RD_LAT), is instantiated; all else flat.

Verification
REQ-041 Write 1 beat addr 3 data 8'hA5 -> one mem_write cycle addr 3 data A5; wr_done pulses once, 1 cycle after that beat.
REQ-042 Read 4 beats from addr 14 after memory preloaded -> mem_addr 14,15,0,1 on consecutive cycles; rsp_data matches, rsp_last on 4th, first rsp 2 cycles after first issue.
REQ-043 Write 3 beats addr 5 with wd_valid toggling 1,0,1,0,1 -> writes at 5,6,7 only on wd_valid cycles; req_ready low throughout.
REQ-044 rst asserted 1 cycle after second read issue of a 4-beat burst -> no rsp_valid afterwards, all outputs at reset values next cycle.
REQ-045 Back-to-back: write 8'h3C to addr 9, then read addr 9 -> rsp_data 8'h3C, rsp_last=1.
